// File: rtl/led_pkg.sv
// Shared definitions for the seven-segment display path: character codes,
// bus widths, scan FSM encoding and the anode-select helper.
package led_pkg;

  localparam int CODE_W = 6;
  localparam int AN_W   = 4;

  // Character codes understood by LEDdecoder
  localparam logic [CODE_W-1:0] CH_0     = 6'd0;
  localparam logic [CODE_W-1:0] CH_1     = 6'd1;
  localparam logic [CODE_W-1:0] CH_2     = 6'd2;
  localparam logic [CODE_W-1:0] CH_3     = 6'd3;
  localparam logic [CODE_W-1:0] CH_4     = 6'd4;
  localparam logic [CODE_W-1:0] CH_5     = 6'd5;
  localparam logic [CODE_W-1:0] CH_6     = 6'd6;
  localparam logic [CODE_W-1:0] CH_7     = 6'd7;
  localparam logic [CODE_W-1:0] CH_8     = 6'd8;
  localparam logic [CODE_W-1:0] CH_9     = 6'd9;
  localparam logic [CODE_W-1:0] CH_A     = 6'd10;
  localparam logic [CODE_W-1:0] CH_B     = 6'd11;
  localparam logic [CODE_W-1:0] CH_C     = 6'd12;
  localparam logic [CODE_W-1:0] CH_D     = 6'd13;
  localparam logic [CODE_W-1:0] CH_E     = 6'd14;
  localparam logic [CODE_W-1:0] CH_F     = 6'd15;
  localparam logic [CODE_W-1:0] CH_SPACE = 6'b100100;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Active-low anode pattern for digit slot d (slot 0 is the leftmost, an[3])
  function automatic logic [AN_W-1:0] anode_mask(input logic [1:0] digit);
    logic [AN_W-1:0] m;
    m = 4'b1111;
    m[2'd3 - digit] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot sequencer: DEAD blanking cycles then ON drive cycles per digit,
// stepping through the four digits and flagging the last cycle of a frame.
module scan_timer
  import led_pkg::*;
#(
  parameter int DEAD = 2,
  parameter int ON   = 4096
) (
  input  logic       clk,
  input  logic       i_reset,
  output logic       o_slot_load,
  output logic       o_drive,
  output logic [1:0] o_digit,
  output logic       o_frame_end
);

  localparam int MAXC = (DEAD > ON) ? DEAD : ON;
  localparam int CW   = $clog2(MAXC + 1);

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_digit, w_digit_nxt;

  // State, phase counter and digit registers
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_digit <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  // Next-state logic: count out each phase, advance digit when a drive ends
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_digit_nxt = r_digit;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == CW'(DEAD - 1)) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == CW'(ON - 1)) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_digit_nxt = r_digit + 2'd1;
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
        w_digit_nxt = 2'd0;
      end
    endcase
  end

  assign o_slot_load = (r_state == ST_BLANK) && (r_cnt == '0);
  assign o_drive     = (r_state == ST_DRIVE);
  assign o_digit     = r_digit;
  assign o_frame_end = (r_state == ST_DRIVE) && (r_cnt == CW'(ON - 1)) &&
                       (r_digit == 2'd3);

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scanner: 16-character message buffer, scroll pointer
// and frame counter, with registered code/anode/frame-tick outputs.
module display_scan_ctrl
  import led_pkg::*;
#(
  parameter int DEAD          = 2,
  parameter int ON            = 4096,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_we,
  input  logic [3:0]        msg_waddr,
  input  logic [CODE_W-1:0] msg_wdata,
  input  logic              scroll_en,
  output logic [CODE_W-1:0] char,
  output logic [AN_W-1:0]   an,
  output logic              frame_tick
);

  localparam int FW = $clog2(SCROLL_FRAMES + 1);

  logic [CODE_W-1:0] r_msg [16];
  logic [3:0]        r_ptr;
  logic [FW-1:0]     r_fcnt;
  logic [CODE_W-1:0] r_char;
  logic [AN_W-1:0]   r_an;
  logic              r_frame_tick;

  logic              w_slot_load;
  logic              w_drive;
  logic [1:0]        w_digit;
  logic              w_frame_end;
  logic [3:0]        w_idx;

  scan_timer #(
    .DEAD (DEAD),
    .ON   (ON)
  ) u_scan_timer (
    .clk         (clk),
    .i_reset     (reset),
    .o_slot_load (w_slot_load),
    .o_drive     (w_drive),
    .o_digit     (w_digit),
    .o_frame_end (w_frame_end)
  );

  // 4-bit add wraps the message index naturally (15 -> 0)
  assign w_idx = r_ptr + {2'b00, w_digit};

  // Message buffer: reset fills with spaces, writes land at the clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_msg[i] <= CH_SPACE;
      end
    end else if (msg_we) begin
      r_msg[msg_waddr] <= msg_wdata;
    end
  end

  // Scroll pointer and frame counter; only move at a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= 4'd0;
      r_fcnt <= '0;
    end else if (!scroll_en) begin
      r_fcnt <= '0;
    end else if (w_frame_end) begin
      if (r_fcnt == FW'(SCROLL_FRAMES - 1)) begin
        r_ptr  <= r_ptr + 4'd1;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  // Registered outputs: code loaded at slot start, anodes follow the phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_char       <= CH_SPACE;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      r_an         <= w_drive ? anode_mask(w_digit) : 4'b1111;
      if (w_slot_load) begin
        r_char <= r_msg[w_idx];
      end
    end
  end

  assign char       = r_char;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a timing/behaviour model pushes the
// expected (anode, code) pair of every digit slot; a monitor pops at each
// drive start and also checks reset values, frame ticks and ghosting rules.
module tb_display_scan_ctrl;
  import led_pkg::*;

  localparam int DEAD  = 2;
  localparam int ON    = 4;
  localparam int SF    = 2;
  localparam int SLOT  = DEAD + ON;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msg_we = 1'b0;
  logic [3:0] msg_waddr = 4'd0;
  logic [5:0] msg_wdata = 6'd0;
  logic       scroll_en = 1'b0;
  logic [5:0] char;
  logic [3:0] an;
  logic       frame_tick;

  display_scan_ctrl #(.DEAD(DEAD), .ON(ON), .SCROLL_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .msg_we(msg_we), .msg_waddr(msg_waddr),
    .msg_wdata(msg_wdata), .scroll_en(scroll_en), .char(char), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] an; logic [5:0] ch; } exp_t;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  logic [5:0] m_msg [16];
  int         m_ptr = 0;
  int         m_fcnt = 0;
  int         m_t = 0;       // edges since the last edge that sampled reset
  bit         m_tick = 1'b0;
  bit         m_rst = 1'b0;
  bit         m_started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_msg[i] = CH_SPACE;
      m_ptr = 0; m_fcnt = 0; m_t = 0; m_tick = 1'b0;
      m_rst = 1'b1; m_started = 1'b1;
      exp_q.delete();
    end else if (m_started) begin
      exp_t e;
      int   d;
      m_rst = 1'b0;
      m_t++;
      // Slot s loads its code one edge after its blanking starts
      if (m_t % SLOT == 1) begin
        d = ((m_t - 1) / SLOT) % 4;
        e.an = 4'b1111;
        e.an[3 - d] = 1'b0;
        e.ch = m_msg[(m_ptr + d) % 16];
        exp_q.push_back(e);
      end
      m_tick = (m_t % FRAME == 0);
      if (!scroll_en) m_fcnt = 0;
      else if (m_tick) begin
        if (m_fcnt == SF - 1) begin
          m_ptr = (m_ptr + 1) % 16; m_fcnt = 0;
        end else m_fcnt++;
      end
      if (msg_we) m_msg[msg_waddr] = msg_wdata;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0] prev_an = 4'b1111;
  logic [5:0] prev_ch = 6'd0;
  int         n_drives = 0;

  always @(negedge clk) begin
    if (m_started) begin
      if (m_rst) begin
        check("reset_an", {28'd0, an}, {28'd0, 4'b1111});
        check("reset_char", {26'd0, char}, {26'd0, CH_SPACE});
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        prev_an = 4'b1111;
      end else begin
        exp_t e;
        check("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
        if ($countones(~an) > 1) check("one_anode", {28'd0, an}, 32'd0);
        if (an != 4'b1111 && prev_an == 4'b1111) begin
          n_drives++;
          if (exp_q.size() == 0) check("unexpected_drive", {28'd0, an}, {28'd0, 4'b1111});
          else begin
            e = exp_q.pop_front();
            check("slot_an", {28'd0, an}, {28'd0, e.an});
            check("slot_char", {26'd0, char}, {26'd0, e.ch});
          end
        end
        if (an != 4'b1111 && prev_an != 4'b1111)
          check("char_stable", {26'd0, char}, {26'd0, prev_ch});
        prev_an = an;
      end
      prev_ch = char;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    msg_we = 1'b1; msg_waddr = a; msg_wdata = d;
    @(negedge clk);
    msg_we = 1'b0;
  endtask

  task automatic wait_ptr(input int target, input int limit);
    int k;
    k = 0;
    while (m_ptr != target && k < limit) begin
      @(negedge clk); k++;
    end
    if (m_ptr != target) check("ptr_timeout", m_ptr, target);
  endtask

  initial begin
    int k;
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed load and display, no scrolling
    wr(4'd0, CH_1); wr(4'd1, CH_2); wr(4'd2, CH_3); wr(4'd3, CH_4);
    cyc(5 * FRAME);

    // Scroll to ptr=15 so the display reads A,1,2,3, then two frames to 1,2,3,space
    wr(4'd15, CH_A); wr(4'd3, CH_SPACE);
    scroll_en = 1'b1;
    wait_ptr(15, 40 * FRAME);
    scroll_en = 1'b0;
    cyc(3 * FRAME);
    scroll_en = 1'b1;
    wait_ptr(0, 4 * FRAME);
    scroll_en = 1'b0;
    cyc(2 * FRAME);

    // Write msg[0] on the very edge that loads digit 0
    k = 0;
    while (!(m_t % FRAME == 0 && m_t > 0) && k < 2 * FRAME) begin
      @(negedge clk); k++;
    end
    if (!(m_t % FRAME == 0)) check("sync_timeout", m_t % FRAME, 0);
    wr(4'd0, CH_E);
    cyc(3 * FRAME);

    // Randomized writes and scroll toggling
    for (int i = 0; i < 2400; i++) begin
      if (i % 97 == 0) scroll_en = ($urandom_range(0, 2) != 0);
      msg_we    = ($urandom_range(0, 3) == 0);
      msg_waddr = 4'($urandom_range(0, 15));
      msg_wdata = 6'($urandom_range(0, 63));
      @(negedge clk);
    end
    msg_we = 1'b0;

    // Reset during the drive phase of digit 2
    k = 0;
    while (!(((m_t / SLOT) % 4 == 2) && (m_t % SLOT >= DEAD + 1)) && k < 2 * FRAME) begin
      @(negedge clk); k++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    scroll_en = 1'b1;
    cyc(3 * FRAME);

    check("pending_slots", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("drive_activity", (n_drives > 400) ? 32'd1 : 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
